// File: rtl/d_cell_cache_pkg.sv
// Shared types for the single-cell tape cache: bus direction encoding,
// controller states and the kind of operation latched at accept time.
package d_cell_cache_pkg;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_GAP,
        ST_FILL,
        ST_ACK,
        ST_FDONE
    } state_e;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_FLUSH
    } op_e;

    function automatic op_e dir_to_op(input logic dir);
        return (dir == DIR_WRITE) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/d_cell_cache.sv
// Single-cell write-back cache between the CPU data port and tape memory.
// Runs of +/- on one cell stay local; the cell is written back only on a miss or flush.
module d_cell_cache
    import d_cell_cache_pkg::*;
#(
    parameter int unsigned d_addr_width = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    c_req,
    input  logic                    c_dir,
    input  logic [d_addr_width-1:0] c_addr,
    input  logic [7:0]              c_wdata,
    output logic                    c_ack,
    output logic [7:0]              c_rdata,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic                    valid_q, valid_d;
    logic                    dirty_q, dirty_d;
    logic [d_addr_width-1:0] tag_q, tag_d;
    logic [7:0]              data_q, data_d;
    logic [d_addr_width-1:0] addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic [7:0]              c_rdata_q, c_rdata_d;
    logic                    hit;

    assign hit = valid_q && (tag_q == c_addr);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (c_req && !c_ack) begin
                    addr_d  = c_addr;
                    wdata_d = c_wdata;
                    op_d    = dir_to_op(c_dir);
                    if (hit) begin
                        if (c_dir == DIR_WRITE) begin
                            data_d  = c_wdata;
                            dirty_d = 1'b1;
                        end else begin
                            c_rdata_d = data_q;
                        end
                        state_d = ST_ACK;
                    end else if (dirty_q) begin
                        state_d = ST_WB;
                    end else if (c_dir == DIR_WRITE) begin
                        // Whole-byte write: install directly, nothing to fetch.
                        tag_d   = c_addr;
                        data_d  = c_wdata;
                        valid_d = 1'b1;
                        dirty_d = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (flush) begin
                    op_d    = OP_FLUSH;
                    state_d = dirty_q ? ST_WB : ST_FDONE;
                end
            end
            ST_WB: begin
                if (d_ack) begin
                    dirty_d = 1'b0;
                    unique case (op_q)
                        OP_FLUSH: state_d = ST_FDONE;
                        OP_WRITE: begin
                            tag_d   = addr_q;
                            data_d  = wdata_q;
                            valid_d = 1'b1;
                            dirty_d = 1'b1;
                            state_d = ST_ACK;
                        end
                        default:  state_d = ST_GAP;
                    endcase
                end
            end
            // One idle bus cycle so the memory's ready flag clears before the fill.
            ST_GAP:  state_d = ST_FILL;
            ST_FILL: begin
                if (d_ack) begin
                    data_d    = d_rdata;
                    tag_d     = addr_q;
                    valid_d   = 1'b1;
                    dirty_d   = 1'b0;
                    c_rdata_d = d_rdata;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK:   state_d = ST_IDLE;
            ST_FDONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            valid_q   <= 1'b0;
            dirty_q   <= 1'b0;
            tag_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
        end
    end

    // Outputs decode straight from the state register so reset drops them at once.
    assign c_ack      = (state_q == ST_ACK);
    assign flush_done = (state_q == ST_FDONE);
    assign c_rdata    = c_rdata_q;
    assign d_req      = (state_q == ST_WB) || (state_q == ST_FILL);
    assign d_dir      = (state_q == ST_WB) ? DIR_WRITE : DIR_READ;
    assign d_addr     = (state_q == ST_FILL) ? addr_q : tag_q;
    assign d_wdata    = data_q;

endmodule

// File: tb/tb_d_cell_cache.sv
// Bench for d_cell_cache: directed vector table, hand-written flush/reset
// sequences, then random traffic against a cell-level reference model.
module tb_d_cell_cache;
    import d_cell_cache_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_req = 1'b0, c_dir = 1'b0, flush = 1'b0;
    logic [7:0] c_addr = '0, c_wdata = '0;
    logic       c_ack, flush_done, d_req, d_dir;
    logic [7:0] c_rdata, d_addr, d_wdata;
    logic       d_ack = 1'b0;
    logic [7:0] d_rdata = '0;

    logic [7:0] mem [256];
    int         txn_count = 0;
    int         viol = 0;
    int         n_pass = 0, n_total = 0;

    d_cell_cache #(.d_addr_width(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_dir(c_dir), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .flush(flush), .flush_done(flush_done),
        .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: answers one cycle after it sees a request, ack lasts one cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h05] = 8'h3C;
        mem[8'h06] = 8'h11;
        forever begin
            @(posedge clk);
            if (!rst_n) d_ack <= 1'b0;
            else if (d_req && !d_ack) begin
                if (d_dir == DIR_WRITE) mem[d_addr] = d_wdata;
                else d_rdata <= mem[d_addr];
                d_ack <= 1'b1;
            end else d_ack <= 1'b0;
        end
    end

    // Bus monitor: completed transactions, gap after each ack, stable request fields.
    logic       p_req = 1'b0, p_ack = 1'b0, p_dir = 1'b0;
    logic [7:0] p_addr = '0, p_wd = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_req = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (p_req && p_ack && d_req) viol++;
            if (p_req && !p_ack && d_req &&
                (d_addr != p_addr || d_dir != p_dir || d_wdata != p_wd)) viol++;
            if (d_req && d_ack) txn_count++;
            p_req = d_req; p_ack = d_ack; p_dir = d_dir; p_addr = d_addr; p_wd = d_wdata;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic do_op(input logic dir, input logic [7:0] addr, input logic [7:0] wd,
                         output int lat, output int txn, output logic [7:0] rd);
        int t0;
        @(negedge clk);
        c_req = 1'b1; c_dir = dir; c_addr = addr; c_wdata = wd;
        t0 = txn_count; lat = 99; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (c_ack) begin
                lat = i; rd = c_rdata;
                break;
            end
        end
        c_req = 1'b0;
        txn = txn_count - t0;
        $display("op %s addr=%02h wdata=%02h -> lat=%0d txn=%0d rdata=%02h",
                 dir == DIR_WRITE ? "WR" : "RD", addr, wd, lat, txn, rd);
    endtask

    task automatic do_flush(output int lat, output int txn);
        int t0;
        @(negedge clk);
        flush = 1'b1; t0 = txn_count; lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (flush_done) begin
                lat = i;
                break;
            end
        end
        flush = 1'b0;
        txn = txn_count - t0;
        $display("flush -> lat=%0d txn=%0d", lat, txn);
    endtask

    typedef struct {
        logic       dir;
        logic [7:0] addr, wdata, exp_rd;
        int         exp_lat, exp_txn;
        logic [7:0] mem_addr, mem_exp;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] ref_cells [256];
    int         lat, txn, lat2;
    logic [7:0] rd;
    logic       m_valid, m_dirty;
    logic [7:0] m_tag;

    initial begin
        vecs[0] = '{DIR_READ,  8'h05, 8'h00, 8'h3C, 3, 1, 8'h05, 8'h3C};
        vecs[1] = '{DIR_WRITE, 8'h05, 8'h41, 8'h00, 1, 0, 8'h05, 8'h3C};
        vecs[2] = '{DIR_READ,  8'h05, 8'h00, 8'h41, 1, 0, 8'h05, 8'h3C};
        vecs[3] = '{DIR_READ,  8'h06, 8'h00, 8'h11, 6, 2, 8'h05, 8'h41};
        vecs[4] = '{DIR_WRITE, 8'h10, 8'h7F, 8'h00, 1, 0, 8'h10, 8'hB5};

        repeat (3) @(negedge clk);
        check("rst_c_ack", int'(c_ack), 0);
        check("rst_flush_done", int'(flush_done), 0);
        check("rst_d_req", int'(d_req), 0);
        check("rst_c_rdata", int'(c_rdata), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            do_op(vecs[v].dir, vecs[v].addr, vecs[v].wdata, lat, txn, rd);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_txn", v), txn, vecs[v].exp_txn);
            if (vecs[v].dir == DIR_READ) check($sformatf("vec%0d_rdata", v), int'(rd), int'(vecs[v].exp_rd));
            check($sformatf("vec%0d_mem", v), int'(mem[vecs[v].mem_addr]), int'(vecs[v].mem_exp));
        end

        // Dirty flush writes back; a second flush on the clean line finishes at once.
        do_flush(lat, txn);
        check("flush1_lat", lat, 3);
        check("flush1_txn", txn, 1);
        check("flush1_mem", int'(mem[8'h10]), 8'h7F);
        do_flush(lat, txn);
        check("flush2_lat", lat, 1);
        check("flush2_txn", txn, 0);

        // Request and flush together: the read is served first.
        @(negedge clk);
        c_req = 1'b1; c_dir = DIR_READ; c_addr = 8'h10; flush = 1'b1;
        lat = 99; lat2 = 99; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (c_ack) begin lat = i; rd = c_rdata; break; end
        end
        c_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (flush_done) begin lat2 = i; break; end
        end
        flush = 1'b0;
        $display("read+flush -> ack lat=%0d rdata=%02h flush_done after %0d", lat, rd, lat2);
        check("both_ack_lat", lat, 1);
        check("both_rdata", int'(rd), 8'h7F);
        check("both_fdone_lat", lat2, 2);

        // Reset while a write-back is on the bus.
        do_op(DIR_WRITE, 8'h20, 8'h99, lat, txn, rd);
        check("wr20_lat", lat, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("wb_d_req_high", int'(d_req), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_d_req", int'(d_req), 0);
        check("rst_async_c_ack", int'(c_ack), 0);
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset during write-back, mem[20]=%02h", mem[8'h20]);
        check("rst_mem20", int'(mem[8'h20]), 8'h85);
        do_op(DIR_READ, 8'h10, 8'h00, lat, txn, rd);
        check("post_rst_lat", lat, 3);
        check("post_rst_txn", txn, 1);
        check("post_rst_rdata", int'(rd), 8'h7F);

        // Random traffic: cells are plain bytes; latency follows from hit/dirty.
        for (int i = 0; i < 256; i++) ref_cells[i] = mem[i];
        m_valid = 1'b1; m_tag = 8'h10; m_dirty = 1'b0;
        for (int it = 0; it < 80; it++) begin
            int         r;
            logic [7:0] a, wd;
            logic       h;
            r  = int'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 7));
            wd = 8'($urandom);
            h  = m_valid && (m_tag == a);
            if (r == 0) begin
                do_flush(lat, txn);
                check($sformatf("rnd%0d_flush_lat", it), lat, m_dirty ? 3 : 1);
                check($sformatf("rnd%0d_flush_txn", it), txn, m_dirty ? 1 : 0);
                m_dirty = 1'b0;
                check($sformatf("rnd%0d_flush_mem", it), int'(mem[m_tag]), int'(ref_cells[m_tag]));
            end else if (r <= 3) begin
                do_op(DIR_WRITE, a, wd, lat, txn, rd);
                check($sformatf("rnd%0d_wr_lat", it), lat, h ? 1 : (m_dirty ? 3 : 1));
                check($sformatf("rnd%0d_wr_txn", it), txn, (!h && m_dirty) ? 1 : 0);
                ref_cells[a] = wd;
                m_valid = 1'b1; m_tag = a; m_dirty = 1'b1;
            end else begin
                do_op(DIR_READ, a, 8'h00, lat, txn, rd);
                check($sformatf("rnd%0d_rd_lat", it), lat, h ? 1 : (m_dirty ? 6 : 3));
                check($sformatf("rnd%0d_rd_txn", it), txn, h ? 0 : (m_dirty ? 2 : 1));
                check($sformatf("rnd%0d_rd_data", it), int'(rd), int'(ref_cells[a]));
                if (!h) m_dirty = 1'b0;
                m_valid = 1'b1; m_tag = a;
            end
        end

        do_flush(lat, txn);
        check("final_flush_lat", lat, m_dirty ? 3 : 1);
        for (int a = 0; a < 8; a++)
            check($sformatf("final_mem%0d", a), int'(mem[a]), int'(ref_cells[a]));
        check("bus_protocol", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
